// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud helpers.
// Used by both the transmitter and the receiver so both ends agree.
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP,
        S_BREAK = ST_BREAK
    } uart_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous board inputs.
// Ports: CLK, RESET (async active-low), raw (async in), synced (out).
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw,
    output logic synced
);

    logic meta;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            meta   <= RESET_VAL;
            synced <= RESET_VAL;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/serial_uart_receiver.sv
// 8N1-style UART receiver with mid-bit sampling and break handling.
// Ports: CLK, RESET (async active-low), UART_RX in; RX_DATA, RX_READY,
// RX_FRAME_ERROR (one-cycle pulses) and RX_BUSY out.
module serial_uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_RATE_HZ = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_READY,
    output logic                 RX_FRAME_ERROR,
    output logic                 RX_BUSY
);

    localparam int BAUD_DIV = baud_div(CLK_RATE_HZ, BAUD_RATE);
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = clog2(BAUD_DIV);
    localparam int IDX_W    = clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    generate
        if (BAUD_DIV < 4) begin : g_bad_baud
            $error("serial_uart_receiver: BAUD_DIV must be >= 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
            $error("serial_uart_receiver: DATA_BITS must be 5..9");
        end
    endgenerate

    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;

    uart_rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .raw   (UART_RX),
        .synced(rx_s)
    );

    assign RX_BUSY = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= S_IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            RX_DATA        <= '0;
            RX_READY       <= 1'b0;
            RX_FRAME_ERROR <= 1'b0;
        end else begin
            RX_READY       <= 1'b0;
            RX_FRAME_ERROR <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= CNT_HALF;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (!rx_s) begin
                        idx   <= '0;
                        cnt   <= CNT_FULL;
                        state <= S_DATA;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        // LSB arrives first, so it ends up at bit 0.
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt   <= CNT_FULL;
                        if (idx == IDX_LAST) begin
                            state <= S_STOP;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (rx_s) begin
                        RX_DATA  <= shreg;
                        RX_READY <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        RX_FRAME_ERROR <= 1'b1;
                        state          <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    // Hold off until the line releases high.
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_uart_receiver.md
# serial_uart_receiver

Receive-side counterpart of the serial UART keypress reporter transmitter. It recovers asynchronous 8N1-style frames from the UART_RX pin, samples each bit at mid-period using a clock-derived baud counter, and presents each byte with a one-cycle ready strobe. It sits between the board RX pin and the command/keypress consumer logic. It uses the same clock, baud and data-width parameters as the transmitter, so both ends are configured identically.

## Interface
- CLK_RATE_HZ, 50000000: system clock frequency, Hz
- BAUD_RATE, 115200: line rate, bits/s
- DATA_BITS, 8: data bits per frame, 5..9, LSB first
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- UART_RX  in  1  serial line, idles high, asynchronous to CLK
- RX_DATA  out  DATA_BITS  last good byte; holds until next good frame
- RX_READY  out  1  one-cycle pulse: RX_DATA newly valid
- RX_FRAME_ERROR  out  1  one-cycle pulse: stop bit sampled low
- RX_BUSY  out  1  high from start-bit acceptance until return to IDLE

## Operation
- Baud constants:
  - BAUD_DIV = (CLK_RATE_HZ + BAUD_RATE/2) / BAUD_RATE, rounded integer.
  - HALF_DIV = BAUD_DIV / 2.
  - Counter width = clog2(BAUD_DIV).
  - BAUD_DIV < 4 is a parameter error.
- Input: UART_RX passes through a 2-FF synchronizer, reset value 1. All decisions use the synchronized value rx_s.
- FSM states:
  - IDLE: on rx_s = 0, load the counter with HALF_DIV-1 and go to START.
  - START: at counter 0, if rx_s = 0, go to DATA with bit index 0 and counter BAUD_DIV-1. Otherwise the start was a glitch: go to IDLE with no outputs.
  - DATA: at counter 0, shift rx_s into the shift register MSB-end (LSB first on the line), then increment the index. After DATA_BITS samples, go to STOP with counter BAUD_DIV-1.
  - STOP: at counter 0, if rx_s = 1, load RX_DATA, pulse RX_READY and go to IDLE. If rx_s = 0, pulse RX_FRAME_ERROR, leave RX_DATA unchanged and go to BREAK.
  - BREAK: wait for rx_s = 1, then go to IDLE. This prevents re-triggering on a held-low line.
- RX_BUSY = (state != IDLE).
- RX_READY and RX_FRAME_ERROR are mutually exclusive and never high two cycles in a row.
- No receive FIFO: the consumer must take RX_DATA before the next RX_READY. Overrun silently overwrites RX_DATA.
- Reset (asynchronous, mid-frame allowed): state IDLE, counters 0, shift register 0, RX_DATA 0, RX_READY 0, RX_FRAME_ERROR 0, RX_BUSY 0, synchronizer 1.
- After reset release, a line already low is treated as a start edge. It is rejected as a glitch only if it is high at mid-start.

## Timing
- Synchronizer latency: 2 CLK.
- Mid-start sample: HALF_DIV cycles after IDLE sees rx_s = 0.
- Data bit k is sampled HALF_DIV + (k+1)*BAUD_DIV cycles after IDLE detection.
- RX_READY / RX_FRAME_ERROR are registered. They go high in the cycle after the stop-bit sample, i.e. HALF_DIV + (DATA_BITS+1)*BAUD_DIV + 1 cycles after IDLE detection.
- Back-to-back frames: the FSM is in IDLE half a bit before the next start edge, so zero gap between frames is supported.
- Tolerated baud mismatch: at least ±2% for DATA_BITS = 8.

## Structure
- Shared package uart_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, STOP, BREAK; 3-bit localparams), shared with the transmitter;
  - the baud divisor and clog2 functions used by both ends.
- Sub-module uart_rx_sync: 2-FF synchronizer with a parameterized reset value of 1. It is reused for other async board inputs.
- The FSM, baud counter, bit index and shift register live in serial_uart_receiver.

## Test plan
Bench uses CLK_RATE_HZ = 1000000, BAUD_RATE = 100000, so BAUD_DIV = 10 and HALF_DIV = 5. It drives UART_RX from a behavioural transmitter.

- **Reset:** hold RESET low 5 cycles with UART_RX = 1 -> all outputs 0, RX_BUSY 0. Assert RESET low mid-frame -> outputs return to 0 immediately and the next full frame is received correctly.
- **Single byte:** send 0xA5 -> RX_DATA = 0xA5 and a single-cycle RX_READY exactly HALF_DIV + 9*BAUD_DIV + 1 = 96 cycles after IDLE detection, with RX_FRAME_ERROR = 0.
- **Back-to-back:** send 0x00, 0xFF, 0x5A with no idle gap -> three RX_READY pulses 100 cycles apart, with data in that order.
- **Glitch:** drive UART_RX low for 3 cycles, then high -> no RX_READY, no RX_FRAME_ERROR, RX_BUSY returns to 0 by mid-start.
- **Framing error / break:** send 0x3C with the stop bit low, then hold the line low for 50 cycles -> one RX_FRAME_ERROR pulse and RX_DATA still at the previous value. No new start is detected until the line goes high. A following 0xC3 is received correctly.
- **Baud skew:** send 0x96 with the transmitter bit period at 9.8 and then 10.2 cycles (±2%) -> RX_DATA = 0x96 in both cases.
